// File: rtl/conway_board_reader.sv
// Snapshots the game-of-life board and streams it out one cell per valid/ready
// transfer, row-major. Optional live-cell counter: define CONWAY_READER_POPCOUNT_EN.
module conway_board_reader #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    localparam int N  = ROWS * COLS,
    localparam int RW = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1,
    localparam int CW = ($clog2(COLS) > 0) ? $clog2(COLS) : 1,
    localparam int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  board_state,
    input  logic          snap,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_data,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last,
    output logic          frame_done,
    output logic [LW-1:0] live_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shadow_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [IW-1:0] idx;
    logic [N-1:0]  shifted;
    logic          cur_bit;
    logic          at_last;
    logic          capture;
    logic          xfer;

    assign at_last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
    assign capture = (state_q == IDLE) && snap;
    assign xfer    = (state_q == SEND) && out_ready;

    // Shift rather than index so non-power-of-two boards need no range guard.
    always_comb begin
        idx     = IW'(row_q) * IW'(COLS) + IW'(col_q);
        shifted = shadow_q >> idx;
        cur_bit = shifted[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (snap) state_d = SEND;
            SEND:    if (out_ready && at_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else if (capture) begin
            shadow_q <= board_state;
            row_q    <= '0;
            col_q    <= '0;
        end else if (xfer && !at_last) begin
            if (col_q == CW'(COLS - 1)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        out_valid  = (state_q == SEND);
        out_data   = (state_q == SEND) && cur_bit;
        out_row    = (state_q == SEND) ? row_q : '0;
        out_col    = (state_q == SEND) ? col_q : '0;
        out_last   = (state_q == SEND) && at_last;
        frame_done = (state_q == DONE);
    end

`ifdef CONWAY_READER_POPCOUNT_EN
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] live_q;

    // The final cell's bit is folded in directly so live_q is ready in the DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            live_q <= '0;
        end else if (capture) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + LW'(cur_bit);
            if (at_last) begin
                live_q <= cnt_q + LW'(cur_bit);
            end
        end
    end

    assign live_count = live_q;
`else
    assign live_count = '0;
`endif

endmodule
